// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths, FSM state and request types for the 1RW+1R SRAM controller
package sram_ctrl_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = 4;
  typedef enum logic [0:0] {CLEAR, RUN} ctrl_state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NUM_WMASKS-1:0] wmask;
  } req_t;
endpackage

// File: rtl/sram_ctrl_rsp_pipe.sv
// sram_ctrl_rsp_pipe: two-stage response valid shift, captures macro dout on the second stage, zeroes write acks
module sram_ctrl_rsp_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  is_write,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic v1, w1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      w1     <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      v1     <= issue;
      w1     <= issue && is_write;
      rvalid <= v1;
      rdata  <= (v1 && !w1) ? dout : '0;
    end
  end
endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: valid/ready initiator for the 32x256 1RW+1R OpenRAM macro with optional zero-fill after reset
// Define SRAM_CTRL_STATS_EN to build the saturating port B conflict stall counter.
module sram_1rw1r_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WMASKS     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [15:0]           stall_cnt
);
  import sram_ctrl_pkg::*;
  localparam ctrl_state_t INIT = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  ctrl_state_t           state;
  logic [ADDR_WIDTH-1:0] clr;
  logic                  a_acc, b_acc, a_iss;
  // the macro is undefined for a same-address write/read, so port B yields to a port A write
  assign a_ready = state == RUN;
  assign b_ready = state == RUN && !(a_valid && a_we && a_addr == b_addr);
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT;
      clr         <= '0;
      a_iss       <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= 1'b1;
      sram_addr1  <= '0;
    end else begin
      a_iss     <= a_acc;
      sram_csb1 <= !b_acc;
      if (b_acc) sram_addr1 <= b_addr;
      if (state == CLEAR) begin
        sram_csb0   <= 1'b0;
        sram_web0   <= 1'b0;
        sram_wmask0 <= '1;
        sram_din0   <= '0;
        sram_addr0  <= clr;
        clr         <= (&clr) ? clr : clr + ADDR_WIDTH'(1);
        if (&clr) state <= RUN;
      end else begin
        sram_csb0 <= !a_acc;
        if (a_acc) begin
          sram_web0  <= !a_we;
          sram_addr0 <= a_addr;
          if (a_we) begin
            sram_wmask0 <= a_wmask;
            sram_din0   <= a_wdata;
          end
        end
      end
    end
  end
  sram_ctrl_rsp_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_a (
    .clk(clk), .rst_n(rst_n), .issue(a_iss), .is_write(!sram_web0),
    .dout(sram_dout0), .rvalid(a_rvalid), .rdata(a_rdata)
  );
  sram_ctrl_rsp_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_b (
    .clk(clk), .rst_n(rst_n), .issue(!sram_csb1), .is_write(1'b0),
    .dout(sram_dout1), .rvalid(b_rvalid), .rdata(b_rdata)
  );
`ifdef SRAM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (state == RUN && b_valid && !b_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: scoreboard bench with a behavioural macro model and a word-level reference memory
module tb_sram_1rw1r_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_wmask = '0;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0, sram_dout1 = '0;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  sram_1rw1r_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
    .stall_cnt(stall_cnt)
  );

  // macro model: pins captured at posedge, write commit and read data at the following negedge
  logic [31:0] mem [256];
  logic        m0_en = 1'b0, m0_we = 1'b0, m1_en = 1'b0, seeded = 1'b0;
  logic [7:0]  m0_a = '0, m1_a = '0;
  logic [3:0]  m0_m = '0;
  logic [31:0] m0_d = '0;
  always @(posedge clk) begin
    m0_en <= !sram_csb0;
    m0_we <= !sram_web0;
    m0_a  <= sram_addr0;
    m0_m  <= sram_wmask0;
    m0_d  <= sram_din0;
    m1_en <= !sram_csb1;
    m1_a  <= sram_addr1;
  end
  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      seeded = 1'b1;
    end
    if (m0_en && m0_we)
      for (int i = 0; i < 4; i++) if (m0_m[i]) mem[m0_a][8*i +: 8] = m0_d[8*i +: 8];
    if (m0_en && !m0_we) sram_dout0 <= mem[m0_a];
    if (m1_en) sram_dout1 <= mem[m1_a];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int t; } exp_t;
  exp_t        qa[$], qb[$];
  logic [31:0] ref_mem [256];
  logic [15:0] exp_stall = '0;
  bit          in_run = 1'b0;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // checks responses of the last edge, then predicts what the next edge accepts
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_rvalid) begin
        if (qa.size() == 0) chk("a_unexpected_rvalid", 64'(a_rvalid), 64'(0));
        else begin
          e = qa.pop_front();
          chk("a_rdata", 64'(a_rdata), 64'(e.d));
          chk("a_latency", 64'(cyc), 64'(e.t));
        end
      end
      if (b_rvalid) begin
        if (qb.size() == 0) chk("b_unexpected_rvalid", 64'(b_rvalid), 64'(0));
        else begin
          e = qb.pop_front();
          chk("b_rdata", 64'(b_rdata), 64'(e.d));
          chk("b_latency", 64'(cyc), 64'(e.t));
        end
      end
      if (!rst_n) begin
        qa.delete();
        qb.delete();
      end else begin
        if (in_run) begin
          chk("a_ready", 64'(a_ready), 64'(1));
          chk("b_ready", 64'(b_ready), 64'(!(a_valid && a_we && a_addr == b_addr)));
`ifdef SRAM_CTRL_STATS_EN
          if (b_valid && a_valid && a_we && a_addr == b_addr && exp_stall != 16'hFFFF) exp_stall++;
`endif
        end
        if (a_valid && a_ready) begin
          if (a_we) begin
            for (int i = 0; i < 4; i++) if (a_wmask[i]) ref_mem[a_addr][8*i +: 8] = a_wdata[8*i +: 8];
            qa.push_back('{32'h0, cyc + 3});
          end else qa.push_back('{ref_mem[a_addr], cyc + 3});
        end
        if (b_valid && b_ready) qb.push_back('{ref_mem[b_addr], cyc + 3});
      end
    end
  endtask

  task automatic do_reset();
    int low, wn, bad;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; in_run = 1'b0; exp_stall = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({a_ready, b_ready, a_rvalid, b_rvalid, sram_csb0, sram_csb1, sram_web0, sram_wmask0}), 64'(11'b0000_111_0000));
    chk("rst_rdata", 64'({a_rdata, b_rdata}), 64'(0));
    chk("rst_pins", 64'({sram_addr0, sram_addr1, sram_din0}), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    low = 0; wn = 0; bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!sram_csb0) begin
        if (sram_web0 || sram_wmask0 != 4'hF || sram_din0 != 32'h0 || sram_addr0 != wn[7:0]) bad++;
        wn++;
      end
      if (a_ready || b_ready) break;
      low++;
    end
    chk("clear_ready_low_cycles", 64'(low), 64'(256));
    chk("clear_write_count", 64'(wn), 64'(256));
    chk("clear_bad_writes", 64'(bad), 64'(0));
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    in_run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input bit av, input bit we, input logic [7:0] aa, input logic [31:0] wd,
                      input logic [3:0] wm, input bit bv, input logic [7:0] ba);
    a_valid = av; a_we = we; a_addr = aa; a_wdata = wd; a_wmask = wm;
    b_valid = bv; b_addr = ba;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic b_rdy_s;
    fork monitor(); join_none
    do_reset();
    send(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h7F);
    idle(4);
    send(1, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 8'h00);
    send(1, 0, 8'h10, 32'h0, 4'h0, 0, 8'h00);
    idle(4);
    send(1, 1, 8'h30, 32'hAAAAAAAA, 4'hF, 0, 8'h00);
    send(1, 1, 8'h30, 32'h11223344, 4'b0101, 0, 8'h00);
    send(1, 0, 8'h30, 32'h0, 4'h0, 1, 8'h30);
    idle(4);
    send(1, 1, 8'h20, 32'hCAFEF00D, 4'hF, 1, 8'h20);
    send(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h20);
    chk("stall_after_collision", 64'(stall_cnt), 64'(exp_stall));
    idle(4);
    for (int i = 0; i < 8; i++) send(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'(i));
    idle(4);
    send(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h05);
    send(0, 0, 8'h00, 32'h0, 4'h0, 1, 8'h06);
    do_reset();
    idle(3);
    b_rdy_s = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!(b_valid && !b_rdy_s)) begin
        b_valid = 1'($urandom_range(0, 1));
        b_addr  = 8'($urandom_range(0, 15));
      end
      a_valid = 1'($urandom_range(0, 1));
      a_we    = 1'($urandom_range(0, 1));
      a_addr  = 8'($urandom_range(0, 15));
      a_wdata = $urandom;
      a_wmask = 4'($urandom_range(0, 15));
      @(negedge clk);
      b_rdy_s = b_ready;
      @(posedge clk); #1;
    end
    idle(6);
    chk("a_pending", 64'(qa.size()), 64'(0));
    chk("b_pending", 64'(qb.size()), 64'(0));
    chk("stall_final", 64'(stall_cnt), 64'(exp_stall));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
